vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Round-robin arbiter sharing the single GPU-side VRAM port among NUM_REQ requesters: rasteriser writes, texture fetch, CPU DMA.
- Sits directly upstream of the VRAM controller's GPU port and honours its mem_en stall, which is low while VGA line fetch owns SRAM.
- Grants bursts of up to MAX_BURST back-to-back accesses per owner, then rotates.
- Registers read data back to the owning requester.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MAX_BURST, 8, max consecutive accepted accesses per ownership (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester access request, held until accepted
we  in  NUM_REQ  1=write, 0=read, per requester
addr  in  NUM_REQ*19  per-requester VRAM word address, requester i at [19i+18:19i]
wdata  in  NUM_REQ*16  per-requester write data
gnt  out  NUM_REQ  one-hot; access accepted in any cycle where req[i]&gnt[i]
rvalid  out  NUM_REQ  one-hot read-return strobe
rdata  out  16  registered read data
mem_en  in  1  VRAM port available this cycle
mem_re  out  1  read strobe to VRAM controller
mem_we  out  1  write strobe to VRAM controller
mem_addr  out  19  address to VRAM controller
mem_wdata  out  16  write data to VRAM controller
mem_rdata  in  16  read data, valid in same cycle as mem_re
stat_clr  in  1  clear statistics (see Optional Feature)
stat_wait  out  NUM_REQ*16  per-requester wait counters

Behaviour:
- Reset (async, rst_n low): state IDLE, rr_ptr=NUM_REQ-1, owner=0, burst_cnt=0, rvalid=0, rdata=0.
  - gnt, mem_re and mem_we are forced 0 while rst_n is low.
  - mem_addr and mem_wdata are 0 while no grant is active.
- gnt and mem_* are combinational from registered state, req and mem_en. mem_we takes priority over mem_re; they are never both 1.
- States:
  - IDLE: if mem_en and |req, pick a winner and grant it this cycle. Winner = first requesting index after rr_ptr, wrapping modulo NUM_REQ. Next state OWN, owner=winner, burst_cnt=1.
  - OWN, continue: if req[owner] and burst_cnt<MAX_BURST and mem_en, grant owner and increment burst_cnt.
  - OWN, rotate: if req[owner]==0 or burst_cnt==MAX_BURST, set rr_ptr=owner. Then, same cycle (mem_en permitting), pick the next winner with owner at lowest priority. If the only requester is the old owner, it is re-granted with burst_cnt=1. If nothing is requesting, go to IDLE.
- mem_en low: no gnt, no mem strobes, and state, owner, burst_cnt and rr_ptr are all held. A requester waiting on a held burst does not lose ownership.
- Read return: when a read is accepted in cycle T:
  - rdata <= mem_rdata and rvalid[owner]=1 in cycle T+1; rvalid is a one-cycle pulse.
  - Back-to-back reads give back-to-back rvalid pulses.
- A requester changing addr, we or wdata while its gnt is 0 is legal. Values are sampled only in the accepting cycle.
- MAX_BURST=1 degenerates to pure per-access round robin.
- Reset mid-burst: ownership dropped, the pending rvalid is discarded, and no partial state survives.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined: per requester, a 16-bit saturating counter increments each cycle req[i]=1 and gnt[i]=0.
  - It saturates at 16'hFFFF.
  - stat_clr=1 zeroes all counters synchronously; clear wins over an increment in the same cycle.
  - Counters reset to 0.
- Undefined: no counters are built, stat_wait is driven to 0, and stat_clr is ignored.

Decomposition:
- Package vram_arb_pkg holds:
  - VRAM_AW=19, VRAM_DW=16
  - arb_state_t enum {ARB_IDLE, ARB_OWN}
  - STAT_W=16
- Sub-module rr_pick holds the combinational round-robin picker: inputs req vector and ptr; outputs found, index, and one-hot. It is instantiated once.

Test Plan:
- Single requester 1 reads addr 19'h00100 with mem_rdata=16'hBEEF, mem_en=1 -> gnt=3'b010 that cycle, mem_re=1, mem_addr=19'h00100; next cycle rvalid=3'b010 and rdata=16'hBEEF.
- All three req held continuously, MAX_BURST=8 -> grant sequence 8xreq0, 8xreq1, 8xreq2, 8xreq0, with no idle cycles between owners.
- req0 bursting, mem_en dropped for 5 cycles after its 3rd access -> gnt=0 and mem strobes 0 for those 5 cycles; req0 resumes with burst_cnt=4 and completes 8 total.
- req2 drops req after 2 accesses while req0 is waiting -> next cycle gnt=3'b001 and rr_ptr=2.
- Assert rst_n low mid-burst one cycle after a read accept -> rvalid stays 0; after release the first request is granted from rr_ptr=NUM_REQ-1, so req0 wins a 3-way tie.
- With VRAM_ARB_STATS_EN: req1 waits 10 cycles behind req0's burst -> stat_wait[31:16]=10; a stat_clr pulse gives 0 next cycle.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared widths and state encoding for the GPU-side VRAM port arbiter.
package vram_arb_pkg;

    localparam int VRAM_AW = 19;
    localparam int VRAM_DW = 16;
    localparam int STAT_W  = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting index after ptr, wrapping,
// so that ptr itself is the lowest-priority candidate.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index,
    output logic [N-1:0]  onehot
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // rot[k] is the request of index ptr+1+k (mod N)
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N:1];

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + (IW + 1)'(1) + {1'b0, off};
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        index = sum[IW-1:0];
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_oh
            assign onehot[gi] = found && (index == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/vram_arbiter.sv
// Round-robin burst arbiter in front of the VRAM controller GPU port.
// Optional per-requester wait statistics are built when VRAM_ARB_STATS_EN is defined.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ*VRAM_AW-1:0]  addr,
    input  logic [NUM_REQ*VRAM_DW-1:0]  wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [VRAM_DW-1:0]          rdata,
    input  logic                        mem_en,
    output logic                        mem_re,
    output logic                        mem_we,
    output logic [VRAM_AW-1:0]          mem_addr,
    output logic [VRAM_DW-1:0]          mem_wdata,
    input  logic [VRAM_DW-1:0]          mem_rdata,
    input  logic                        stat_clr,
    output logic [NUM_REQ*STAT_W-1:0]   stat_wait
);

    localparam int          IW        = $clog2(NUM_REQ);
    localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);

    arb_state_t             state_reg;
    logic [IW-1:0]          rr_ptr_reg;
    logic [IW-1:0]          owner_reg;
    logic [7:0]             burst_cnt_reg;
    logic [NUM_REQ-1:0]     rvalid_reg;
    logic [VRAM_DW-1:0]     rdata_reg;

    logic                   cont;
    logic                   grant;
    logic [IW-1:0]          pick_ptr;
    logic                   pick_found;
    logic [IW-1:0]          pick_idx;
    logic [NUM_REQ-1:0]     pick_oh;
    logic [IW-1:0]          sel;
    logic                   sel_we;
    logic [VRAM_AW-1:0]     addr_arr  [NUM_REQ];
    logic [VRAM_DW-1:0]     wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
            assign addr_arr[gi]  = addr[gi*VRAM_AW +: VRAM_AW];
            assign wdata_arr[gi] = wdata[gi*VRAM_DW +: VRAM_DW];
        end
    endgenerate

    // While owning, the picker starts after the owner so the owner ranks last on rotation.
    assign cont     = (state_reg == ARB_OWN) && req[owner_reg] && (burst_cnt_reg < BURST_MAX);
    assign pick_ptr = (state_reg == ARB_OWN) ? owner_reg : rr_ptr_reg;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .index  (pick_idx),
        .onehot (pick_oh)
    );

    assign grant     = rst_n && mem_en && (cont || pick_found);
    assign sel       = cont ? owner_reg : pick_idx;
    assign sel_we    = we[sel];
    assign mem_we    = grant && sel_we;
    assign mem_re    = grant && !sel_we;
    assign mem_addr  = grant ? addr_arr[sel]  : '0;
    assign mem_wdata = grant ? wdata_arr[sel] : '0;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt[gi] = grant && (cont ? (owner_reg == IW'(gi)) : pick_oh[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ARB_IDLE;
            rr_ptr_reg    <= IW'(NUM_REQ - 1);
            owner_reg     <= '0;
            burst_cnt_reg <= '0;
            rvalid_reg    <= '0;
            rdata_reg     <= '0;
        end else begin
            rvalid_reg <= '0;
            if (grant && !sel_we) begin
                rvalid_reg <= gnt;
                rdata_reg  <= mem_rdata;
            end
            // A stalled port freezes the whole arbitration state, ownership included.
            if (mem_en) begin
                if (cont) begin
                    burst_cnt_reg <= burst_cnt_reg + 8'd1;
                end else begin
                    if (state_reg == ARB_OWN) begin
                        rr_ptr_reg <= owner_reg;
                    end
                    if (pick_found) begin
                        state_reg     <= ARB_OWN;
                        owner_reg     <= pick_idx;
                        burst_cnt_reg <= 8'd1;
                    end else begin
                        state_reg     <= ARB_IDLE;
                        burst_cnt_reg <= '0;
                    end
                end
            end
        end
    end

    assign rvalid = rvalid_reg;
    assign rdata  = rdata_reg;

`ifdef VRAM_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [STAT_W-1:0] wait_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wait_reg <= '0;
                end else if (stat_clr) begin
                    wait_reg <= '0;
                end else if (req[gi] && !gnt[gi] && (wait_reg != '1)) begin
                    wait_reg <= wait_reg + STAT_W'(1);
                end
            end
            assign stat_wait[gi*STAT_W +: STAT_W] = wait_reg;
        end
    endgenerate
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_wait       = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a spec-level model compared every cycle.
module tb_vram_arbiter;

    localparam int N  = 3;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  we = '0;
    logic [N*19-1:0] addr = {19'h2ABCD, 19'h00100, 19'h01234};
    logic [N*16-1:0] wdata = {16'hC2C2, 16'hB1B1, 16'hA0A0};
    logic [N-1:0]  gnt;
    logic [N-1:0]  rvalid;
    logic [15:0]   rdata;
    logic          mem_en = 1'b1;
    logic          mem_re;
    logic          mem_we;
    logic [18:0]   mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata = 16'h0000;
    logic          stat_clr = 1'b0;
    logic [N*16-1:0] stat_wait;

    vram_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stat_clr  (stat_clr),
        .stat_wait (stat_wait)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner (-1 when nobody owns), accesses in current burst, rotation pointer.
    int          m_owner = -1;
    int          m_cnt   = 0;
    int          m_ptr   = N - 1;
    logic [N-1:0] m_rvalid = '0;
    logic [15:0] m_rdata  = '0;
    int          m_wait [N] = '{0, 0, 0};

    function automatic int exp_winner();
        int base;
        if (!rst_n || !mem_en) return -1;
        if (m_owner >= 0 && req[m_owner] && m_cnt < MB) return m_owner;
        base = (m_owner >= 0) ? m_owner : m_ptr;
        for (int k = 1; k <= N; k++) begin
            if (req[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int  w;
        bit  keep;
        if (!rst_n) begin
            m_owner  = -1;
            m_cnt    = 0;
            m_ptr    = N - 1;
            m_rvalid = '0;
            m_rdata  = '0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else begin
            w    = exp_winner();
            keep = (m_owner >= 0) && req[m_owner] && (m_cnt < MB);
            for (int i = 0; i < N; i++) begin
                if (stat_clr) m_wait[i] = 0;
                else if (req[i] && w != i && m_wait[i] < 65535) m_wait[i]++;
            end
            m_rvalid = '0;
            if (w >= 0) begin
                if (keep) m_cnt++;
                else begin
                    if (m_owner >= 0) m_ptr = m_owner;
                    m_owner = w;
                    m_cnt   = 1;
                end
                if (!we[w]) begin
                    m_rvalid[w] = 1'b1;
                    m_rdata     = mem_rdata;
                end
            end else if (mem_en && m_owner >= 0) begin
                m_ptr   = m_owner;
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int w;
        logic [N-1:0] eg;
        w  = exp_winner();
        eg = (w >= 0) ? (3'b001 << w) : 3'b000;
        check("gnt", gnt, eg);
        check("mem_we", mem_we, (w >= 0) && we[w]);
        check("mem_re", mem_re, (w >= 0) && !we[w]);
        if (w >= 0) begin
            check("mem_addr", mem_addr, addr[w*19 +: 19]);
            if (we[w]) check("mem_wdata", mem_wdata, wdata[w*16 +: 16]);
        end else begin
            check("mem_addr_idle", mem_addr, 0);
            check("mem_wdata_idle", mem_wdata, 0);
        end
        check("rvalid", rvalid, m_rvalid);
        check("rdata", rdata, m_rdata);
`ifdef VRAM_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("stat_wait", stat_wait[i*16 +: 16], m_wait[i]);
`else
        check("stat_wait_off", stat_wait, 0);
`endif
    end

    task automatic step(input logic [N-1:0] exp_gnt, input string tag);
        @(negedge clk);
        check({tag, "_gnt"}, gnt, exp_gnt);
        if (exp_gnt == 0) check({tag, "_strobe"}, {mem_re, mem_we}, 2'b00);
        $display("txn %s req=%b mem_en=%b gnt=%b rvalid=%b", tag, req, mem_en, gnt, rvalid);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 3'b000);
        check("rst_rvalid", rvalid, 3'b000);
        check("rst_rdata", rdata, 16'h0000);
        rst_n = 1'b1;

        // Three-way contention, 8-access bursts rotating 0,1,2,0
        req = 3'b111;
        we  = 3'b101;
        for (int i = 0; i < 32; i++) step(3'b001 << ((i / 8) % 3), "rr8");
        req = 3'b000;
        step(3'b000, "rr8_end");

        // Single read from requester 1
        we        = 3'b000;
        req       = 3'b010;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        check("rd_gnt", gnt, 3'b010);
        check("rd_mem_re", mem_re, 1'b1);
        check("rd_mem_addr", mem_addr, 19'h00100);
        $display("txn rd1 req=%b gnt=%b addr=%h", req, gnt, mem_addr);
        @(posedge clk);
        #1;
        req       = 3'b000;
        mem_rdata = 16'h0000;
        @(negedge clk);
        check("rd_rvalid", rvalid, 3'b010);
        check("rd_rdata", rdata, 16'hBEEF);
        $display("txn rd1_ret rvalid=%b rdata=%h", rvalid, rdata);
        @(posedge clk);
        #1;

        // Burst of req0 with a 5-cycle port stall after its 3rd access
        req = 3'b011;
        for (int i = 0; i < 3; i++) begin
            mem_rdata = 16'(16'h1000 + i);
            step(3'b001, "stall_pre");
        end
        mem_en = 1'b0;
        for (int i = 0; i < 5; i++) step(3'b000, "stall");
        mem_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_rdata = 16'(16'h2000 + i);
            step(3'b001, "stall_post");
        end
        step(3'b010, "stall_rot");
        req = 3'b000;
        step(3'b000, "stall_end");

        // req2 leaves early while req0 waits
        req = 3'b101;
        step(3'b100, "drop");
        step(3'b100, "drop");
        req = 3'b001;
        step(3'b001, "drop_rot");
        req = 3'b000;
        step(3'b000, "drop_end");

        // Reset one cycle after a read accept
        req       = 3'b111;
        mem_rdata = 16'h5A5A;
        step(3'b010, "rst_mid");
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_rvalid", rvalid, 3'b000);
        check("rstmid_gnt", gnt, 3'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3'b001, "rst_tie");
        req = 3'b000;
        step(3'b000, "rst_end");

        // Wait statistics: req1 waits behind req0 for 10 cycles
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 3'b011;
        for (int i = 0; i < 4; i++) step(3'b001, "stat");
        mem_en = 1'b0;
        for (int i = 0; i < 2; i++) step(3'b000, "stat_stall");
        mem_en = 1'b1;
        for (int i = 0; i < 4; i++) step(3'b001, "stat");
        req = 3'b010;
        step(3'b010, "stat_rot");
        req = 3'b000;
        @(negedge clk);
`ifdef VRAM_ARB_STATS_EN
        check("stat_req1", stat_wait[31:16], 16'd10);
        check("stat_req0", stat_wait[15:0], 16'd2);
`else
        check("stat_off", stat_wait, 48'd0);
`endif
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        @(negedge clk);
        check("stat_clr", stat_wait, 48'd0);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
